branch_cond_unit: RTL
=====================

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 SHALL have parameter NUM_CC, default 4, number of condition-code (CC) registers (>=1).
REQ-002 SHALL have parameter CC_IDX_W, default 2, CC index width (>= ceil(log2(NUM_CC)), min 1).
REQ-003 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-004 SHALL have parameter ANNUL_EN, default 1; 0 forces annul_out to 0.
REQ-005 Clocking: one clock; reset is asynchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 cc_issue  in  1  an instruction entering EX will write a CC.
REQ-009 cc_issue_idx  in  CC_IDX_W  target CC of that instruction.
REQ-010 cc_wr  in  1  flag write-back this cycle.
REQ-011 cc_wr_idx  in  CC_IDX_W  CC written.
REQ-012 cc_wr_flags  in  4  {Z,N,C,V}, bit3..bit0.
REQ-013 id_branch_valid  in  1  conditional branch present in ID.
REQ-014 id_cond  in  4  condition code field.
REQ-015 id_cc_idx  in  CC_IDX_W  CC tested.
REQ-016 id_annul  in  1  annul bit of branch.
REQ-017 stall  out  1  combinational; branch held in ID.
REQ-018 branch_valid_out  out  1  registered; resolution valid.
REQ-019 branch_taken  out  1  registered; branch taken.
REQ-020 annul_out  out  1  registered; squash delay slot.
REQ-021 branch_cnt, taken_cnt  out  CNT_W each  resolved / taken counts.

Function
REQ-022 SHALL hold NUM_CC 4-bit CC registers; cc_wr writes cc_wr_flags to entry cc_wr_idx at clock edge; index >= NUM_CC ignored.
REQ-023 SHALL keep one pending bit per CC: cc_issue sets, cc_wr clears; same idx set and clear in one cycle -> pending stays 1.
REQ-024 Effective flags: if cc_wr and cc_wr_idx==id_cc_idx -> cc_wr_flags (forward), else stored register.
REQ-025 stall = id_branch_valid & pending[id_cc_idx] & ~(cc_wr & cc_wr_idx==id_cc_idx & ~(cc_issue & cc_issue_idx==id_cc_idx)).
REQ-026 Resolution SHALL occur at the edge where id_branch_valid=1 and stall=0; outputs valid the following cycle (latency 1); branch_valid_out is a 1-cycle pulse per resolution.
REQ-027 Conditions: 0000 never; 0001 Z; 0010 Z|(N^V); 0011 N^V; 0100 C|Z; 0101 C; 0110 N; 0111 V; 1000 always; 1001..1111 complements of 0001..0111 in order.
REQ-028 annul_out = ANNUL_EN & id_annul & (~taken | id_cond==1000).
REQ-029 While not resolving, branch_taken and annul_out SHALL be 0.
REQ-030 Counters increment on resolution (taken_cnt only if taken); SHALL saturate at all-ones, not wrap.
REQ-031 Stalled branch SHALL NOT change outputs or counters; resolves once stall drops.

Reset
REQ-032 On reset low, asynchronously: all CC registers 0, pending bits 0, branch_valid_out/branch_taken/annul_out 0, counters 0; stall drops to 0 immediately.
REQ-033 Reset mid-stall SHALL discard the held branch; no resolution after release unless re-presented.

Verification
REQ-034 Write CC1=1000 (Z), then branch cond 0001 idx 1 -> next cycle valid=1, taken=1, annul=0.
REQ-035 cc_issue idx2, branch idx2 next cycle -> stall=1 until cc_wr idx2 flags 0100; same cycle stall=0, forwarded N gives cond 0110 taken=1.
REQ-036 Branch cond 0000 annul=1 -> taken=0, annul_out=1; cond 1000 annul=1 -> taken=1, annul_out=1; ANNUL_EN=0 -> annul_out=0.
REQ-037 CNT_W=2, five taken branches -> branch_cnt=taken_cnt=3, held.
REQ-038 Reset asserted while stall=1 -> stall=0, counters 0; no branch_valid_out after release.
REQ-039 Same-cycle cc_issue and cc_wr on idx0 with branch on idx0 pending -> stall stays 1.

Source files
------------

// File: rtl/branch_cond_if.sv
// branch_cond_if: CC write-back, branch-in-ID and resolution bundle for branch_cond_unit
interface branch_cond_if #(
  parameter int CC_IDX_W = 2,
  parameter int CNT_W = 16
);
  logic cc_issue;
  logic [CC_IDX_W-1:0] cc_issue_idx;
  logic cc_wr;
  logic [CC_IDX_W-1:0] cc_wr_idx;
  logic [3:0] cc_wr_flags;
  logic id_branch_valid;
  logic [3:0] id_cond;
  logic [CC_IDX_W-1:0] id_cc_idx;
  logic id_annul;
  logic stall;
  logic branch_valid_out;
  logic branch_taken;
  logic annul_out;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] taken_cnt;
  modport master (
    output cc_issue, cc_issue_idx, cc_wr, cc_wr_idx, cc_wr_flags,
           id_branch_valid, id_cond, id_cc_idx, id_annul,
    input  stall, branch_valid_out, branch_taken, annul_out, branch_cnt, taken_cnt
  );
  modport slave (
    input  cc_issue, cc_issue_idx, cc_wr, cc_wr_idx, cc_wr_flags,
           id_branch_valid, id_cond, id_cc_idx, id_annul,
    output stall, branch_valid_out, branch_taken, annul_out, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_cond_unit.sv
// branch_cond_unit: CC scoreboard with write-back forwarding, branch condition resolution and saturating stats
module branch_cond_unit #(
  parameter int NUM_CC = 4,
  parameter int CC_IDX_W = 2,
  parameter int CNT_W = 16,
  parameter int ANNUL_EN = 1
) (
  input logic clk,
  input logic rst_n,
  branch_cond_if.slave bus
);
  localparam int N_IDX = 2 ** CC_IDX_W;
  localparam bit ANN = ANNUL_EN != 0;
  logic [3:0] cc_q [NUM_CC];
  logic pend_q [NUM_CC];
  logic [3:0] cc_rd [N_IDX];
  logic [N_IDX-1:0] pend_rd;
  logic fwd, iss, stall, resolve, taken;
  logic [3:0] flags;
  logic [7:0] tbl;
  logic valid_q, taken_q, annul_q;
  logic [CNT_W-1:0] bcnt_q, tcnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < NUM_CC; k++) begin
        cc_q[k] <= '0;
        pend_q[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_CC; k++) begin
        if (bus.cc_wr && bus.cc_wr_idx == CC_IDX_W'(k)) cc_q[k] <= bus.cc_wr_flags;
        if (bus.cc_issue && bus.cc_issue_idx == CC_IDX_W'(k)) pend_q[k] <= 1'b1;
        else if (bus.cc_wr && bus.cc_wr_idx == CC_IDX_W'(k)) pend_q[k] <= 1'b0;
      end
    end
  // Indices with no backing register read as clean, never-pending zeros
  genvar j;
  generate
    for (j = 0; j < N_IDX; j++) begin : g_rd
      if (j < NUM_CC) begin : g_real
        assign cc_rd[j] = cc_q[j];
        assign pend_rd[j] = pend_q[j];
      end else begin : g_pad
        assign cc_rd[j] = 4'd0;
        assign pend_rd[j] = 1'b0;
      end
    end
  endgenerate
  // Conditions 1xxx are the complement of 0xxx; 1000 falls out as "always" since 0000 is "never"
  always_comb begin
    fwd = bus.cc_wr && bus.cc_wr_idx == bus.id_cc_idx;
    iss = bus.cc_issue && bus.cc_issue_idx == bus.id_cc_idx;
    flags = fwd ? bus.cc_wr_flags : cc_rd[bus.id_cc_idx];
    tbl = {flags[0], flags[2], flags[1], flags[1] | flags[3], flags[2] ^ flags[0],
           flags[3] | (flags[2] ^ flags[0]), flags[3], 1'b0};
    taken = bus.id_cond[3] ^ tbl[bus.id_cond[2:0]];
    stall = bus.id_branch_valid & pend_rd[bus.id_cc_idx] & ~(fwd & ~iss);
    resolve = bus.id_branch_valid & ~stall;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      annul_q <= 1'b0;
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      valid_q <= resolve;
      taken_q <= resolve & taken;
      annul_q <= resolve & ANN & bus.id_annul & (~taken | bus.id_cond == 4'b1000);
      if (resolve && !(&bcnt_q)) bcnt_q <= bcnt_q + 1'b1;
      if (resolve && taken && !(&tcnt_q)) tcnt_q <= tcnt_q + 1'b1;
    end
  assign bus.stall = stall;
  assign bus.branch_valid_out = valid_q;
  assign bus.branch_taken = taken_q;
  assign bus.annul_out = annul_q;
  assign bus.branch_cnt = bcnt_q;
  assign bus.taken_cnt = tcnt_q;
endmodule
